taillight_monitor: RTL and testbench
====================================

Name: taillight_monitor

Overview:
- Receive-side checker for the 6-bit taillight bus driven by the taillight controller/dimmer pair.
- Samples `lights` on `dim_clk` and strips run-light dimming to recover the undimmed pattern.
- Decodes each side (right = [5:3], left = [2:0]) into a mode: OFF / TURN / HAZARD / BRAKE. Flags illegal codes and illegal sequence jumps.
- Used in bench self-checking and in on-board diagnostics.

Parameters:
- STEADY_CYC, 16, number of `dim_clk` cycles a side code must hold unchanged before it is classified as steady. Must exceed the number of `dim_clk` cycles per controller `clk` period.
- CW, 8, width of the per-side steady counter. Must satisfy 2^CW > STEADY_CYC.

Ports:
- dim_clk, input, 1, sampling clock; all state updates on its rising edge.
- rst, input, 1, reset: synchronous, active-high.
- lights, input, 6, dimmed light bus; right [5:3], left [2:0].
- run_light, input, 1, run-light enable, same signal that drives the dimmer.
- pattern, output, 6, recovered undimmed pattern (registered).
- right_mode, output, 3, decoded right-side mode.
- left_mode, output, 3, decoded left-side mode.
- mode_chg, output, 1, one-cycle pulse when either mode register changes value.
- err, output, 1, one-cycle pulse on an illegal code or illegal jump on either side.
- err_sticky, output, 1, set by `err`; cleared only by `rst`.

Behaviour:
- Mode encoding: 0 OFF, 1 TURN, 2 HAZARD, 3 BRAKE, 4 UNKNOWN. Values 5–7 are never driven.
- Reset values: `pattern` = 0, both modes = 4 (UNKNOWN), `mode_chg` = 0, `err` = 0, `err_sticky` = 0. Internal sample registers, previous codes and counters are all cleared. Reset mid-operation aborts all history the same way.

Stage 1 (sampling):
- `s0 <= lights`, `s1 <= s0`, `rl <= run_light`.

Stage 2 (undim):
- If `rl` = 0: `pattern <= s0`.
- If `rl` = 1: `pattern <= s0` if `s0` != 6'h3F; otherwise `s1` if `s1` != 6'h3F; otherwise 6'h3F.
- Latency: a change on `lights` reaches `pattern` 2 cycles later.

Side code extraction (per side, from `pattern`):
- Right [5:3]: 000→0, 001→1, 011→2, 111→3.
- Left [2:0]: 000→0, 100→1, 110→2, 111→3.
- Any other 3-bit value is illegal.

Stage 3 (classify, per side, independent):
- Code unchanged from the previous `pattern`:
  - Counter increments, saturating at STEADY_CYC.
  - The cycle the counter becomes equal to STEADY_CYC: code 0 → OFF; code 3 → BRAKE; code 1 or 2 → UNKNOWN and `err`.
- Code changed: counter clears to 0, then the transition is classified:
  - 0→1, 1→2, 2→3: TURN.
  - 0→3: HAZARD.
  - 3→0 while mode is TURN or HAZARD: mode held.
  - 3→0 while mode is BRAKE, UNKNOWN or OFF: OFF.
  - Any other transition (e.g. 1→0, 0→2, 3→1, 2→1): mode UNKNOWN and `err`.
- Illegal code: mode UNKNOWN and `err`, every cycle it is present. The previous code is stored as "invalid", so the next legal code is treated as an unchanged-code case with the counter cleared.
- Latency: a side mode updates 1 cycle after `pattern`, i.e. 3 cycles after `lights`.
- `mode_chg` and `err` are asserted in the same cycle as the mode register update.
- Simultaneous events: left and right errors in the same cycle produce a single `err` pulse. `mode_chg` fires if either side changes.
- `run_light` toggling mid-stream requires no special handling; the window rule applies on every cycle.

Test Plan:
- Reset and idle:
  - Stimulus: `rst` = 1 for 2 cycles, then `lights` = 0, `run_light` = 0 for 20 cycles.
  - Required: modes = 4 until cycle 2+STEADY_CYC after reset, then both modes = 0. `mode_chg` pulses once. `err` stays 0.
- Right turn:
  - Stimulus: `lights` steps 000000 → 001000 → 011000 → 111000 → 000000, each held 4 cycles, repeated 3 times.
  - Required: `right_mode` = 1 three cycles after the first step and held throughout. `left_mode` = 0. No `err`.
- Hazard:
  - Stimulus: `lights` alternates 000000 / 111111, 4 cycles each.
  - Required: both modes = 2 three cycles after the first 111111 and held. No `err`.
- Brake with run light:
  - Stimulus: `run_light` = 1; dimmer output alternates 111000 / 111111 every cycle for 30 cycles.
  - Required: `pattern` constantly 111000. `right_mode` = 3 after STEADY_CYC. `left_mode` = 0. No `err`.
- Off with run light:
  - Stimulus: `run_light` = 1; `lights` alternates 000000 / 111111 every cycle for 30 cycles.
  - Required: `pattern` = 0. Both modes = 0. No hazard detection.
- Illegal jump and code:
  - Stimulus: right side 001000 → 000000; later `lights` = 010000.
  - Required: `err` pulses 3 cycles after each event. `right_mode` = 4. `err_sticky` = 1 until `rst`.

Source files
------------

// File: rtl/taillight_monitor.sv
// taillight_monitor: receive-side checker for the 6-bit taillight bus.
// Strips run-light dimming to recover the undimmed pattern, decodes each
// side into OFF / TURN / HAZARD / BRAKE / UNKNOWN, and flags illegal codes
// and illegal sequence jumps.
module taillight_monitor #(
    parameter int STEADY_CYC = 16,
    parameter int CW         = 8
) (
    input  logic       dim_clk,
    input  logic       rst,
    input  logic [5:0] lights,
    input  logic       run_light,
    output logic [5:0] pattern,
    output logic [2:0] right_mode,
    output logic [2:0] left_mode,
    output logic       mode_chg,
    output logic       err,
    output logic       err_sticky
);

    localparam logic [2:0] MODE_OFF = 3'd0;
    localparam logic [2:0] MODE_TRN = 3'd1;
    localparam logic [2:0] MODE_HAZ = 3'd2;
    localparam logic [2:0] MODE_BRK = 3'd3;
    localparam logic [2:0] MODE_UNK = 3'd4;

    localparam logic [5:0]    ALL_ON = 6'h3F;
    localparam logic [CW-1:0] STEADY = CW'(STEADY_CYC);

    // Per-side classifier state. vld = 0 means the previous code was illegal.
    typedef struct packed {
        logic          vld;
        logic [1:0]    code;
        logic [CW-1:0] cnt;
        logic [2:0]    mode;
    } side_t;

    localparam side_t SIDE_RST = '{vld: 1'b1, code: 2'd0, cnt: '0, mode: MODE_UNK};

    logic [5:0] s0_q, s1_q;
    logic       rl_q;
    logic [5:0] pattern_d, pattern_q;
    side_t      right_d, right_q, left_d, left_q;
    logic       right_err, left_err;
    logic       mode_chg_q, err_q, err_sticky_q;

    // Right side codes grow from the outer bit: 000, 001, 011, 111.
    function automatic logic [2:0] dec_right(input logic [2:0] b);
        logic [2:0] r;
        case (b)
            3'b000:  r = 3'b100;
            3'b001:  r = 3'b101;
            3'b011:  r = 3'b110;
            3'b111:  r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;   // {legal, code}
    endfunction

    // Left side is mirrored: 000, 100, 110, 111.
    function automatic logic [2:0] dec_left(input logic [2:0] b);
        logic [2:0] r;
        case (b)
            3'b000:  r = 3'b100;
            3'b100:  r = 3'b101;
            3'b110:  r = 3'b110;
            3'b111:  r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // One classification step for a side; both sides share the same rules.
    function automatic void side_next(input side_t cur, input logic [2:0] dec,
                                      output side_t nx, output logic e);
        logic          legal;
        logic [1:0]    code;
        logic [CW-1:0] cnt_inc;
        legal   = dec[2];
        code    = dec[1:0];
        cnt_inc = cur.cnt + 1'b1;
        nx      = cur;
        e       = 1'b0;
        if (!legal) begin
            nx.vld  = 1'b0;
            nx.cnt  = '0;
            nx.mode = MODE_UNK;
            e       = 1'b1;
        end else if (!cur.vld || code == cur.code) begin
            // Recovering from an illegal code counts as an unchanged code.
            nx.vld  = 1'b1;
            nx.code = code;
            if (cur.cnt != STEADY) begin
                nx.cnt = cnt_inc;
                if (cnt_inc == STEADY) begin
                    case (code)
                        2'd0:    nx.mode = MODE_OFF;
                        2'd3:    nx.mode = MODE_BRK;
                        default: begin
                            nx.mode = MODE_UNK;
                            e       = 1'b1;
                        end
                    endcase
                end
            end
        end else begin
            nx.vld  = 1'b1;
            nx.code = code;
            nx.cnt  = '0;
            case ({cur.code, code})
                4'b00_01, 4'b01_10, 4'b10_11: nx.mode = MODE_TRN;
                4'b00_11:                     nx.mode = MODE_HAZ;
                4'b11_00: begin
                    // End of a turn or hazard cycle keeps the running mode.
                    if (cur.mode == MODE_TRN || cur.mode == MODE_HAZ)
                        nx.mode = cur.mode;
                    else
                        nx.mode = MODE_OFF;
                end
                default: begin
                    nx.mode = MODE_UNK;
                    e       = 1'b1;
                end
            endcase
        end
    endfunction

    // Undim: during run-light the dimmer inserts all-on frames; take the
    // newest sample that is not all-on, or all-on if both samples are.
    always_comb begin
        pattern_d = s0_q;
        if (rl_q && s0_q == ALL_ON) begin
            pattern_d = (s1_q != ALL_ON) ? s1_q : ALL_ON;
        end
    end

    // Classify both sides from the current recovered pattern.
    always_comb begin
        right_d   = right_q;
        left_d    = left_q;
        right_err = 1'b0;
        left_err  = 1'b0;
        side_next(right_q, dec_right(pattern_q[5:3]), right_d, right_err);
        side_next(left_q,  dec_left(pattern_q[2:0]),  left_d,  left_err);
    end

    // Sampling, undim and classification pipeline with event pulses.
    always_ff @(posedge dim_clk) begin
        if (rst) begin
            s0_q         <= '0;
            s1_q         <= '0;
            rl_q         <= 1'b0;
            pattern_q    <= '0;
            right_q      <= SIDE_RST;
            left_q       <= SIDE_RST;
            mode_chg_q   <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            s0_q         <= lights;
            s1_q         <= s0_q;
            rl_q         <= run_light;
            pattern_q    <= pattern_d;
            right_q      <= right_d;
            left_q       <= left_d;
            mode_chg_q   <= (right_d.mode != right_q.mode) || (left_d.mode != left_q.mode);
            err_q        <= right_err | left_err;
            err_sticky_q <= err_sticky_q | right_err | left_err;
        end
    end

    assign pattern    = pattern_q;
    assign right_mode = right_q.mode;
    assign left_mode  = left_q.mode;
    assign mode_chg   = mode_chg_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_taillight_monitor.sv
// Bench for taillight_monitor: directed scenarios followed by randomized
// traffic, every cycle compared against a history-based reference model.
module tb_taillight_monitor;

    localparam int STEADY = 16;

    logic       dim_clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] lights = '0;
    logic       run_light = 1'b0;
    logic [5:0] pattern;
    logic [2:0] right_mode, left_mode;
    logic       mode_chg, err, err_sticky;

    int checks = 0;
    int errors = 0;

    taillight_monitor #(.STEADY_CYC(STEADY), .CW(8)) dut (
        .dim_clk    (dim_clk),
        .rst        (rst),
        .lights     (lights),
        .run_light  (run_light),
        .pattern    (pattern),
        .right_mode (right_mode),
        .left_mode  (left_mode),
        .mode_chg   (mode_chg),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 dim_clk = ~dim_clk;

    // Reference model: input history since reset plus per-side mode state.
    logic [5:0] lh[$];
    logic       rh[$];
    logic [5:0] m_pat;
    int r_prev, r_run, r_mode, l_prev, l_run, l_mode;
    bit m_chg, m_err, m_sticky;

    function automatic int code_of(input logic [2:0] b, input bit left);
        logic [2:0] b2;
        b2 = left ? {b[0], b[1], b[2]} : b;   // mirror left onto right shape
        case (b2)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b011:  return 2;
            3'b111:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [5:0] undim(input logic [5:0] a, input logic [5:0] b, input logic r);
        if (!r || a != 6'h3F) return a;
        if (b != 6'h3F) return b;
        return 6'h3F;
    endfunction

    function automatic void side_step(input int code, inout int prev, inout int run,
                                      inout int mode, output bit e);
        int t;
        e = 0;
        if (code < 0) begin
            prev = -1; run = 0; mode = 4; e = 1;
        end else if (prev < 0 || prev == code) begin
            prev = code;
            if (run < STEADY) begin
                run++;
                if (run == STEADY) begin
                    if (code == 0) mode = 0;
                    else if (code == 3) mode = 3;
                    else begin mode = 4; e = 1; end
                end
            end
        end else begin
            t = prev * 4 + code;
            if (t == 1 || t == 6 || t == 11) mode = 1;
            else if (t == 3) mode = 2;
            else if (t == 12) mode = (mode == 1 || mode == 2) ? mode : 0;
            else begin mode = 4; e = 1; end
            prev = code;
            run  = 0;
        end
    endfunction

    task automatic model_reset();
        lh.delete(); rh.delete();
        m_pat = '0;
        r_prev = 0; r_run = 0; r_mode = 4;
        l_prev = 0; l_run = 0; l_mode = 4;
        m_chg = 0; m_err = 0; m_sticky = 0;
    endtask

    task automatic model_edge(input logic [5:0] l, input logic r);
        logic [5:0] a, b, np;
        logic       ra;
        int om_r, om_l;
        bit er, el;
        a  = (lh.size() >= 1) ? lh[lh.size()-1] : 6'h00;
        b  = (lh.size() >= 2) ? lh[lh.size()-2] : 6'h00;
        ra = (rh.size() >= 1) ? rh[rh.size()-1] : 1'b0;
        np = undim(a, b, ra);
        om_r = r_mode; om_l = l_mode;
        side_step(code_of(m_pat[5:3], 0), r_prev, r_run, r_mode, er);
        side_step(code_of(m_pat[2:0], 1), l_prev, l_run, l_mode, el);
        m_chg    = (r_mode != om_r) || (l_mode != om_l);
        m_err    = er || el;
        m_sticky = m_sticky || m_err;
        m_pat    = np;
        lh.push_back(l); rh.push_back(r);
        if (lh.size() > 4) begin void'(lh.pop_front()); void'(rh.pop_front()); end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] l, input logic r, input logic rs);
        lights = l; run_light = r; rst = rs;
        @(posedge dim_clk);
        if (rs) model_reset(); else model_edge(l, r);
        #1;
        chk("pattern",    {2'b0, pattern},    {2'b0, m_pat});
        chk("right_mode", {5'b0, right_mode}, 8'(r_mode));
        chk("left_mode",  {5'b0, left_mode},  8'(l_mode));
        chk("mode_chg",   {7'b0, mode_chg},   {7'b0, m_chg});
        chk("err",        {7'b0, err},        {7'b0, m_err});
        chk("err_sticky", {7'b0, err_sticky}, {7'b0, m_sticky});
    endtask

    task automatic hold(input logic [5:0] l, input logic r, input int n);
        for (int i = 0; i < n; i++) cyc(l, r, 1'b0);
    endtask

    logic [2:0] rpat[4];
    logic [2:0] lpat[4];
    int chg_cnt;

    initial begin
        rpat[0] = 3'b000; rpat[1] = 3'b001; rpat[2] = 3'b011; rpat[3] = 3'b111;
        lpat[0] = 3'b000; lpat[1] = 3'b100; lpat[2] = 3'b110; lpat[3] = 3'b111;
        model_reset();

        // Reset and idle
        cyc(6'h00, 1'b0, 1'b1);
        cyc(6'h00, 1'b0, 1'b1);
        chk("rst_right_mode", {5'b0, right_mode}, 8'd4);
        chk("rst_pattern",    {2'b0, pattern},    8'd0);
        chg_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(6'h00, 1'b0, 1'b0);
            if (mode_chg) chg_cnt++;
        end
        chk("idle_right_off", {5'b0, right_mode}, 8'd0);
        chk("idle_left_off",  {5'b0, left_mode},  8'd0);
        chk("idle_chg_once",  8'(chg_cnt),        8'd1);

        // Right turn sequence, three rounds
        for (int rep = 0; rep < 3; rep++) begin
            hold(6'h00, 1'b0, 4); hold(6'h08, 1'b0, 4);
            hold(6'h18, 1'b0, 4); hold(6'h38, 1'b0, 4);
        end
        hold(6'h00, 1'b0, 4);
        chk("turn_right", {5'b0, right_mode}, 8'd1);
        chk("turn_left",  {5'b0, left_mode},  8'd0);
        chk("turn_noerr", {7'b0, err_sticky}, 8'd0);

        // Hazard
        for (int rep = 0; rep < 6; rep++) begin
            hold(6'h3F, 1'b0, 4); hold(6'h00, 1'b0, 4);
        end
        chk("haz_right", {5'b0, right_mode}, 8'd2);
        chk("haz_left",  {5'b0, left_mode},  8'd2);

        // Brake with run light (dimmer inserts all-on frames)
        for (int i = 0; i < 30; i++) cyc((i % 2) ? 6'h3F : 6'h38, 1'b1, 1'b0);
        chk("brake_pattern", {2'b0, pattern},    8'h38);
        chk("brake_right",   {5'b0, right_mode}, 8'd3);
        chk("brake_left",    {5'b0, left_mode},  8'd0);

        // Off with run light
        for (int i = 0; i < 30; i++) cyc((i % 2) ? 6'h3F : 6'h00, 1'b1, 1'b0);
        chk("off_pattern", {2'b0, pattern},    8'h00);
        chk("off_right",   {5'b0, right_mode}, 8'd0);
        chk("off_left",    {5'b0, left_mode},  8'd0);

        // Illegal jump then illegal code
        hold(6'h00, 1'b0, 20);
        hold(6'h08, 1'b0, 4);
        hold(6'h00, 1'b0, 4);
        chk("jump_sticky", {7'b0, err_sticky}, 8'd1);
        chk("jump_right",  {5'b0, right_mode}, 8'd4);
        hold(6'h10, 1'b0, 4);
        hold(6'h00, 1'b0, 6);
        chk("illegal_right",  {5'b0, right_mode}, 8'd4);
        chk("illegal_sticky", {7'b0, err_sticky}, 8'd1);
        cyc(6'h00, 1'b0, 1'b1);
        chk("sticky_cleared", {7'b0, err_sticky}, 8'd0);

        // Randomized traffic with occasional illegal codes, dimming and reset
        for (int seg = 0; seg < 120; seg++) begin
            logic [2:0] rb, lb;
            logic [5:0] v;
            logic       r;
            int         len;
            rb  = rpat[$urandom_range(3)];
            lb  = lpat[$urandom_range(3)];
            if ($urandom_range(9) == 0) rb = 3'($urandom);
            if ($urandom_range(9) == 0) lb = 3'($urandom);
            r   = 1'($urandom_range(1));
            len = $urandom_range(1, 22);
            for (int i = 0; i < len; i++) begin
                v = {rb, lb};
                if (r && $urandom_range(1) == 1) v = 6'h3F;
                cyc(v, r, 1'b0);
            end
            if ($urandom_range(29) == 0) cyc(6'h00, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
